hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Producer side of the D-stage forwarding path in the five-stage MIPS core.
- Tracks destination-register and Tnew records for the E, M and W stages, and compares them against the instruction currently in D.
- From that comparison it generates the 4-bit forward-select codes (DRD1Judge/DRD2Judge) consumed by the D-stage RD1/RD2 forwarding muxes, the pipeline stall/bubble controls, and a mult/div busy counter.
- Sits beside the D/E/M/W pipeline registers and is clocked with them.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E.
- DIV_CYCLES, 10, busy cycles after a div/divu enters E.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- D_rs  in  5  rs field of instruction in D
- D_rt  in  5  rt field of instruction in D
- D_Tuse_rs  in  2  cycles until rs is needed; 3 = not used
- D_Tuse_rt  in  2  cycles until rt is needed; 3 = not used
- D_wreg  in  5  destination register of D instruction; 0 = none
- D_Tnew  in  2  Tnew the D instruction will have on entering E
- D_isjal  in  1  D instruction writes PC+8
- D_md_start  in  1  D is mult/multu/div/divu
- D_md_div  in  1  with D_md_start: 1 = div, 0 = mult
- D_md_use  in  1  D is an mfhi/mflo/mthi/mtlo/mult/div instruction
- DRD1Judge  out  4  forward select for rs: 0 none, 1 E PC+8, 2 M result, 3 W DataSelected
- DRD2Judge  out  4  same encoding, for rt
- Eisjal  out  1  E record is jal
- Misjal  out  1  M record is jal
- stall  out  1  freeze PC and the F/D register
- E_clr  out  1  load a bubble into the D/E register (equals stall)
- md_busy  out  1  mult/div unit counter nonzero

Behaviour:
- State: three records (E, M, W), each holding wreg[4:0], Tnew[1:0], isjal, md_start, md_div. Plus md_cnt[3:0].
- Reset (async, active-high): all records cleared to wreg=0, Tnew=0, flags 0; md_cnt=0. Outputs: both Judges 0, stall 0, md_busy 0, Eisjal/Misjal 0.
- Every posedge (reset low):
  - W <= M with Tnew = sat0(M.Tnew-1).
  - M <= E with Tnew = sat0(E.Tnew-1).
  - E <= D fields if stall=0; otherwise E <= bubble (all zero). D inputs are held externally during stall.
- md_cnt per posedge:
  - If E.md_start: md_cnt <= DIV_CYCLES when E.md_div, else MULT_CYCLES.
  - Else if md_cnt != 0: md_cnt <= md_cnt - 1.
  - md_busy = (md_cnt != 0), registered.
- stall (combinational from state and D inputs) is the OR of:
  - D_rs != 0, D_rs == E.wreg, D_Tuse_rs < E.Tnew
  - D_rs != 0, D_rs == M.wreg, D_Tuse_rs < M.Tnew
  - the same two terms for rt
  - D_md_use && (md_busy || E.md_start)
- DRD1Judge (combinational), priority E > M > W. Register 0 is never forwarded.
  - 1 if D_rs == E.wreg != 0, E.Tnew == 0, E.isjal
  - else 2 if D_rs == M.wreg != 0, M.Tnew == 0
  - else 3 if D_rs == W.wreg != 0
  - else 0
- DRD2Judge: identical rule using D_rt.
- A stale older match never wins over a younger producer. If E matches with Tnew > 0, the result is a stall with Judge 0 from the E term; M/W are not consulted for that operand.
- Eisjal = E.isjal and Misjal = M.isjal, straight from the records.
- Tnew of 3 is illegal input and is treated as 2.
- A reset during mult/div busy clears md_cnt immediately; no residual stall.

Decomposition:
- Shared package (cpu_pkg): forward codes FWD_NONE=0, FWD_E=1, FWD_M=2, FWD_W=3; TUSE_NONE=3; the stage record typedef.
- One sub-module, fwd_select: a pure combinational compare of one source register against the three records, yielding a 4-bit Judge plus a stall term. Instantiated twice, for rs and rt.

Test Plan:
- add $1 (Tnew=1) then beq $1,$0 (Tuse_rs=0) → stall=1 for 1 cycle, E_clr=1. Next cycle add is in M with Tnew=0 → DRD1Judge=2, stall=0.
- lw $2 (Tnew=2) then add $3,$2,$0 (Tuse_rs=1) → stall=1 for 1 cycle. Then lw is in M with Tnew=1 → Judge=0. A following beq $2 one cycle later → Judge=3 from W.
- jal (wreg=31, Tnew=0, isjal) then jr $31 (Tuse=0) → no stall, DRD1Judge=1, Eisjal=1. Next cycle with jr held artificially → DRD1Judge=2, Misjal=1.
- ori $0 (wreg=0) then beq $0,$0 → DRD1Judge=DRD2Judge=0, stall=0.
- mult then mflo (md_use=1) immediately → stall=1 for 6 cycles (E cycle + 5 busy), md_busy high 5 cycles. Same with div → 11 cycles.
- div issued, reset pulsed 3 cycles later → md_busy=0, stall=0, all Judges 0 asynchronously on reset assertion.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the D-stage hazard and forwarding controller.
package hazard_forward_ctrl_pkg;

   typedef enum logic [3:0] {
      FWD_NONE = 4'd0,
      FWD_E    = 4'd1,
      FWD_M    = 4'd2,
      FWD_W    = 4'd3
   } fwd_sel_e;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef struct packed {
      logic [4:0] wreg;
      logic [1:0] tnew;
      logic       isjal;
      logic       md_start;
      logic       md_div;
   } stage_rec_t;

   localparam stage_rec_t REC_BUBBLE = '0;

   // One stage of progress brings a result one cycle closer, never below zero.
   function automatic logic [1:0] tnew_age(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic [1:0] tnew_clamp(input logic [1:0] t);
      return (t == 2'd3) ? 2'd2 : t;
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Compares one D-stage source register against the E/M/W records and yields
// its forward-select code plus the data-hazard stall term for that operand.
module fwd_select
   import hazard_forward_ctrl_pkg::*;
(
   input  logic [4:0] i_src,
   input  logic [1:0] i_tuse,
   input  logic [4:0] i_e_wreg,
   input  logic [1:0] i_e_tnew,
   input  logic       i_e_isjal,
   input  logic [4:0] i_m_wreg,
   input  logic [1:0] i_m_tnew,
   input  logic [4:0] i_w_wreg,
   output logic [3:0] o_judge,
   output logic       o_stall
);

   logic     w_e_hit;
   logic     w_m_hit;
   logic     w_w_hit;
   fwd_sel_e w_sel;

   assign w_e_hit = (i_src != 5'd0) && (i_src == i_e_wreg);
   assign w_m_hit = (i_src != 5'd0) && (i_src == i_m_wreg);
   assign w_w_hit = (i_src != 5'd0) && (i_src == i_w_wreg);

   assign o_stall = (w_e_hit && (i_tuse < i_e_tnew)) ||
                    (w_m_hit && (i_tuse < i_m_tnew));

   // The youngest matching producer owns the operand, even when its value is
   // not ready yet; an older stage is then never allowed to supply stale data.
   always_comb begin
      w_sel = FWD_NONE;
      if (w_e_hit) begin
         if ((i_e_tnew == 2'd0) && i_e_isjal) w_sel = FWD_E;
      end else if (w_m_hit) begin
         if (i_m_tnew == 2'd0) w_sel = FWD_M;
      end else if (w_w_hit) begin
         w_sel = FWD_W;
      end
   end

   assign o_judge = w_sel;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// D-stage hazard unit: tracks E/M/W destination records, produces forward
// selects for RD1/RD2, the stall/bubble controls and the mult/div busy counter.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic [4:0] D_wreg,
   input  logic [1:0] D_Tnew,
   input  logic       D_isjal,
   input  logic       D_md_start,
   input  logic       D_md_div,
   input  logic       D_md_use,
   output logic [3:0] DRD1Judge,
   output logic [3:0] DRD2Judge,
   output logic       Eisjal,
   output logic       Misjal,
   output logic       stall,
   output logic       E_clr,
   output logic       md_busy
);

   stage_rec_t r_e, r_m, r_w;
   logic [3:0] r_md_cnt;

   stage_rec_t w_d_rec, w_e_next, w_m_next, w_w_next;
   logic [3:0] w_md_next;
   logic       w_rs_stall, w_rt_stall, w_md_stall, w_stall;
   logic       w_unused_rec;

   fwd_select u_fwd_rs (
      .i_src     (D_rs),
      .i_tuse    (D_Tuse_rs),
      .i_e_wreg  (r_e.wreg),
      .i_e_tnew  (r_e.tnew),
      .i_e_isjal (r_e.isjal),
      .i_m_wreg  (r_m.wreg),
      .i_m_tnew  (r_m.tnew),
      .i_w_wreg  (r_w.wreg),
      .o_judge   (DRD1Judge),
      .o_stall   (w_rs_stall)
   );

   fwd_select u_fwd_rt (
      .i_src     (D_rt),
      .i_tuse    (D_Tuse_rt),
      .i_e_wreg  (r_e.wreg),
      .i_e_tnew  (r_e.tnew),
      .i_e_isjal (r_e.isjal),
      .i_m_wreg  (r_m.wreg),
      .i_m_tnew  (r_m.tnew),
      .i_w_wreg  (r_w.wreg),
      .o_judge   (DRD2Judge),
      .o_stall   (w_rt_stall)
   );

   assign md_busy    = (r_md_cnt != 4'd0);
   assign w_md_stall = D_md_use && (md_busy || r_e.md_start);
   assign w_stall    = w_rs_stall || w_rt_stall || w_md_stall;
   assign stall      = w_stall;
   assign E_clr      = w_stall;
   assign Eisjal     = r_e.isjal;
   assign Misjal     = r_m.isjal;

   always_comb begin
      w_d_rec = '{wreg: D_wreg, tnew: tnew_clamp(D_Tnew), isjal: D_isjal,
                  md_start: D_md_start, md_div: D_md_div};
      w_e_next      = w_stall ? REC_BUBBLE : w_d_rec;
      w_m_next      = r_e;
      w_m_next.tnew = tnew_age(r_e.tnew);
      w_w_next      = r_m;
      w_w_next.tnew = tnew_age(r_m.tnew);

      w_md_next = r_md_cnt;
      if (r_e.md_start) begin
         w_md_next = r_e.md_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (r_md_cnt != 4'd0) begin
         w_md_next = r_md_cnt - 4'd1;
      end
   end

   // NOTE: all next-state is formed combinationally above; the flops only take non-blocking updates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e      <= REC_BUBBLE;
         r_m      <= REC_BUBBLE;
         r_w      <= REC_BUBBLE;
         r_md_cnt <= 4'd0;
      end else begin
         r_e      <= w_e_next;
         r_m      <= w_m_next;
         r_w      <= w_w_next;
         r_md_cnt <= w_md_next;
      end
   end

   // W's timing/flag fields and M's mult/div flags ride along with the record but drive nothing.
   assign w_unused_rec = ^{r_w.tnew, r_w.isjal, r_w.md_start, r_w.md_div,
                           r_m.md_start, r_m.md_div};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios plus
// randomized instruction streams against an in-flight-instruction model.
module tb_hazard_forward_ctrl;
   import hazard_forward_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] D_rs, D_rt, D_wreg;
   logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
   logic       D_isjal, D_md_start, D_md_div, D_md_use;
   logic [3:0] DRD1Judge, DRD2Judge;
   logic       Eisjal, Misjal, stall, E_clr, md_busy;

   always #5 clk = ~clk;

   hazard_forward_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
      .D_wreg(D_wreg), .D_Tnew(D_Tnew), .D_isjal(D_isjal),
      .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
      .DRD1Judge(DRD1Judge), .DRD2Judge(DRD2Judge), .Eisjal(Eisjal), .Misjal(Misjal),
      .stall(stall), .E_clr(E_clr), .md_busy(md_busy)
   );

   typedef struct {
      logic [4:0] rs, rt, wreg;
      logic [1:0] tuse_rs, tuse_rt, tnew;
      bit         isjal, md_start, md_div, md_use;
   } instr_t;

   // An instruction in flight: its result is ready (ready0 - age) cycles after entering E.
   typedef struct {
      logic [4:0] dest;
      int         ready0;
      bit         isjal;
      bit         md;
      int         enter;
   } flight_t;

   int        n_tests = 0;
   int        n_fail  = 0;
   int        cyc     = 0;
   int        md_enter = -100;
   int        md_len   = 0;
   flight_t   q[$];
   instr_t    cur;

   function automatic instr_t nop();
      instr_t d;
      d.rs = 5'd0; d.rt = 5'd0; d.wreg = 5'd0;
      d.tuse_rs = TUSE_NONE; d.tuse_rt = TUSE_NONE; d.tnew = 2'd0;
      d.isjal = 1'b0; d.md_start = 1'b0; d.md_div = 1'b0; d.md_use = 1'b0;
      return d;
   endfunction

   function automatic int m_ready(input flight_t f);
      int a;
      a = cyc - f.enter;
      return (f.ready0 > a) ? f.ready0 - a : 0;
   endfunction

   function automatic logic [3:0] m_judge(input logic [4:0] src);
      int best_i, best_a;
      best_i = -1;
      best_a = 99;
      if (src == 5'd0) return 4'd0;
      foreach (q[i]) begin
         int a;
         a = cyc - q[i].enter;
         if (a >= 0 && a <= 2 && q[i].dest == src && a < best_a) begin
            best_a = a;
            best_i = i;
         end
      end
      if (best_i < 0) return 4'd0;
      if (best_a == 0) return (m_ready(q[best_i]) == 0 && q[best_i].isjal) ? 4'd1 : 4'd0;
      if (best_a == 1) return (m_ready(q[best_i]) == 0) ? 4'd2 : 4'd0;
      return 4'd3;
   endfunction

   function automatic bit m_op_stall(input logic [4:0] src, input logic [1:0] tuse);
      foreach (q[i]) begin
         int a;
         a = cyc - q[i].enter;
         if (src != 5'd0 && (a == 0 || a == 1) && q[i].dest == src && int'(tuse) < m_ready(q[i]))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit m_at_age(input int age, input bit want_md);
      foreach (q[i]) begin
         if (cyc - q[i].enter == age) return want_md ? q[i].md : q[i].isjal;
      end
      return 1'b0;
   endfunction

   function automatic bit m_busy();
      return (cyc > md_enter) && (cyc <= md_enter + md_len);
   endfunction

   function automatic bit m_stall();
      return m_op_stall(cur.rs, cur.tuse_rs) || m_op_stall(cur.rt, cur.tuse_rt) ||
             (cur.md_use && (m_busy() || m_at_age(0, 1'b1)));
   endfunction

   task automatic drive(input instr_t d);
      cur = d;
      D_rs = d.rs; D_rt = d.rt; D_Tuse_rs = d.tuse_rs; D_Tuse_rt = d.tuse_rt;
      D_wreg = d.wreg; D_Tnew = d.tnew; D_isjal = d.isjal;
      D_md_start = d.md_start; D_md_div = d.md_div; D_md_use = d.md_use;
      #1;
   endtask

   task automatic tick();
      bit s;
      s = m_stall();
      @(posedge clk);
      if (!s) begin
         q.push_back('{dest: cur.wreg, ready0: (cur.tnew == 2'd3) ? 2 : int'(cur.tnew),
                       isjal: cur.isjal, md: cur.md_start, enter: cyc + 1});
         if (cur.md_start) begin
            md_enter = cyc + 1;
            md_len   = cur.md_div ? 10 : 5;
         end
      end
      cyc++;
      while (q.size() > 0 && cyc - q[0].enter > 2) void'(q.pop_front());
      @(negedge clk);
   endtask

   task automatic assert_reset();
      reset = 1'b1;
      q.delete();
      md_enter = -100;
      #1;
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      instr_t d;
      d = nop();
      d.rs = 5'd31; d.rt = 5'd5; d.tuse_rs = 2'd0; d.tuse_rt = 2'd0; d.md_use = 1'b1;
      drive(d);
      assert_reset();
      n_tests++;
      if ({DRD1Judge, DRD2Judge} !== 8'h00) begin
         n_fail++; $display("FAIL reset_judge: got %h want 00", {DRD1Judge, DRD2Judge});
      end
      n_tests++;
      if ({stall, E_clr, md_busy, Eisjal, Misjal} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {stall, E_clr, md_busy, Eisjal, Misjal});
      end
      release_reset();
   endtask

   task automatic test_alu_raw();
      instr_t d;
      assert_reset(); release_reset();
      d = nop(); d.wreg = 5'd1; d.tnew = 2'd1; drive(d); tick();
      d = nop(); d.rs = 5'd1; d.tuse_rs = 2'd0; drive(d);
      n_tests++;
      if ({stall, E_clr, DRD1Judge} !== {1'b1, 1'b1, 4'd0}) begin
         n_fail++; $display("FAIL alu_raw_stall: stall/E_clr/judge got %b%b/%0d want 11/0", stall, E_clr, DRD1Judge);
      end
      tick();
      n_tests++;
      if ({stall, DRD1Judge} !== {1'b0, 4'd2}) begin
         n_fail++; $display("FAIL alu_raw_fwd: stall/judge got %b/%0d want 0/2", stall, DRD1Judge);
      end
   endtask

   task automatic test_load_use();
      instr_t d;
      assert_reset(); release_reset();
      d = nop(); d.wreg = 5'd2; d.tnew = 2'd2; drive(d); tick();
      d = nop(); d.rs = 5'd2; d.tuse_rs = 2'd1; d.wreg = 5'd3; d.tnew = 2'd1; drive(d);
      n_tests++;
      if ({stall, DRD1Judge} !== {1'b1, 4'd0}) begin
         n_fail++; $display("FAIL load_use_stall: stall/judge got %b/%0d want 1/0", stall, DRD1Judge);
      end
      tick();
      n_tests++;
      if ({stall, DRD1Judge} !== {1'b0, 4'd0}) begin
         n_fail++; $display("FAIL load_use_m: stall/judge got %b/%0d want 0/0", stall, DRD1Judge);
      end
      tick();
      d = nop(); d.rs = 5'd2; d.tuse_rs = 2'd0; drive(d);
      n_tests++;
      if ({stall, DRD1Judge} !== {1'b0, 4'd3}) begin
         n_fail++; $display("FAIL load_use_w: stall/judge got %b/%0d want 0/3", stall, DRD1Judge);
      end
   endtask

   task automatic test_jal();
      instr_t d;
      assert_reset(); release_reset();
      d = nop(); d.wreg = 5'd31; d.tnew = 2'd0; d.isjal = 1'b1; drive(d); tick();
      d = nop(); d.rs = 5'd31; d.tuse_rs = 2'd0; drive(d);
      n_tests++;
      if ({stall, DRD1Judge, Eisjal} !== {1'b0, 4'd1, 1'b1}) begin
         n_fail++; $display("FAIL jal_e: stall/judge/Eisjal got %b/%0d/%b want 0/1/1", stall, DRD1Judge, Eisjal);
      end
      tick();
      n_tests++;
      if ({stall, DRD1Judge, Misjal, Eisjal} !== {1'b0, 4'd2, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL jal_m: stall/judge/Misjal/Eisjal got %b/%0d/%b/%b want 0/2/1/0",
                            stall, DRD1Judge, Misjal, Eisjal);
      end
   endtask

   task automatic test_zero_reg();
      instr_t d;
      assert_reset(); release_reset();
      d = nop(); d.wreg = 5'd0; d.tnew = 2'd1; drive(d); tick();
      d = nop(); d.tuse_rs = 2'd0; d.tuse_rt = 2'd0; drive(d);
      n_tests++;
      if ({stall, DRD1Judge, DRD2Judge} !== {1'b0, 8'h00}) begin
         n_fail++; $display("FAIL zero_reg: stall/j1/j2 got %b/%0d/%0d want 0/0/0", stall, DRD1Judge, DRD2Judge);
      end
   endtask

   task automatic test_md(input bit is_div);
      instr_t d;
      int n_stall, n_busy, want;
      assert_reset(); release_reset();
      want = is_div ? 11 : 6;
      d = nop(); d.md_start = 1'b1; d.md_div = is_div; d.md_use = 1'b1; drive(d); tick();
      d = nop(); d.md_use = 1'b1; d.wreg = 5'd4; d.tnew = 2'd1; drive(d);
      n_stall = 0;
      n_busy  = 0;
      for (int k = 0; k < 40; k++) begin
         if (!stall) break;
         n_stall++;
         if (md_busy) n_busy++;
         tick();
      end
      n_tests++;
      if (n_stall != want) begin
         n_fail++; $display("FAIL md_stall_len(div=%0b): got %0d want %0d", is_div, n_stall, want);
      end
      n_tests++;
      if (n_busy != want - 1 || md_busy !== 1'b0) begin
         n_fail++; $display("FAIL md_busy_len(div=%0b): got %0d (now %b) want %0d (now 0)",
                            is_div, n_busy, md_busy, want - 1);
      end
   endtask

   task automatic test_reset_during_div();
      instr_t d;
      assert_reset(); release_reset();
      d = nop(); d.md_start = 1'b1; d.md_div = 1'b1; d.md_use = 1'b1; drive(d); tick();
      d = nop(); d.wreg = 5'd6; d.tnew = 2'd1; drive(d); tick();
      d = nop(); d.rs = 5'd6; d.rt = 5'd6; d.md_use = 1'b1; drive(d); tick();
      n_tests++;
      if ({md_busy, stall, DRD1Judge, DRD2Judge} !== {1'b1, 1'b1, 4'd2, 4'd2}) begin
         n_fail++; $display("FAIL div_pre_reset: busy/stall/j1/j2 got %b/%b/%0d/%0d want 1/1/2/2",
                            md_busy, stall, DRD1Judge, DRD2Judge);
      end
      assert_reset();
      n_tests++;
      if ({md_busy, stall, E_clr, DRD1Judge, DRD2Judge, Eisjal, Misjal} !== 13'b0) begin
         n_fail++; $display("FAIL div_reset: busy/stall/eclr/j1/j2 got %b/%b/%b/%0d/%0d want all 0",
                            md_busy, stall, E_clr, DRD1Judge, DRD2Judge);
      end
      release_reset();
      n_tests++;
      if ({md_busy, stall} !== 2'b00) begin
         n_fail++; $display("FAIL div_after_reset: busy/stall got %b/%b want 0/0", md_busy, stall);
      end
   endtask

   function automatic instr_t rand_instr();
      instr_t d;
      int k;
      d = nop();
      d.rs = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      d.rt = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      d.tuse_rs = 2'($urandom_range(0, 3));
      d.tuse_rt = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 15);
      if (k == 0) begin
         d.wreg = 5'd31; d.tnew = 2'd0; d.isjal = 1'b1;
      end else if (k == 1) begin
         d.md_start = 1'b1; d.md_div = 1'($urandom_range(0, 1)); d.md_use = 1'b1;
      end else if (k == 2) begin
         d.md_use = 1'b1; d.wreg = 5'($urandom_range(1, 7)); d.tnew = 2'd1;
      end else if (k < 5) begin
         d.tnew = 2'($urandom_range(0, 3));
      end else begin
         d.wreg = 5'($urandom_range(0, 7));
         d.tnew = (d.wreg == 5'd0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
      end
      return d;
   endfunction

   task automatic test_random();
      logic [12:0] exp_v, act_v;
      bit          s;
      assert_reset(); release_reset();
      drive(rand_instr());
      for (int i = 0; i < 600; i++) begin
         s     = m_stall();
         exp_v = {m_judge(cur.rs), m_judge(cur.rt), s, s, m_busy(), m_at_age(0, 1'b0), m_at_age(1, 1'b0)};
         act_v = {DRD1Judge, DRD2Judge, stall, E_clr, md_busy, Eisjal, Misjal};
         n_tests++;
         if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL random[%0d] j1,j2,stall,eclr,busy,ejal,mjal: got %h,%h,%b want %h,%h,%b",
                     i, act_v[12:9], act_v[8:5], act_v[4:0], exp_v[12:9], exp_v[8:5], exp_v[4:0]);
         end
         tick();
         if (!s) drive(rand_instr());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drive(nop());
      @(negedge clk);
      test_reset();
      test_alu_raw();
      test_load_use();
      test_jal();
      test_zero_reg();
      test_md(1'b0);
      test_md(1'b1);
      test_reset_during_div();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
